// File: rtl/vid_timing_pkg.sv
// Shared types, register map and colour-bar palette for the raster timing controller.
package vid_timing_pkg;

  typedef logic [11:0] tfield_t;

  localparam int NUM_FLD = 8;

  localparam logic [2:0] FLD_H_ACTIVE = 3'd0;
  localparam logic [2:0] FLD_H_FP     = 3'd1;
  localparam logic [2:0] FLD_H_SYNC   = 3'd2;
  localparam logic [2:0] FLD_H_BP     = 3'd3;
  localparam logic [2:0] FLD_V_ACTIVE = 3'd4;
  localparam logic [2:0] FLD_V_FP     = 3'd5;
  localparam logic [2:0] FLD_V_SYNC   = 3'd6;
  localparam logic [2:0] FLD_V_BP     = 3'd7;
  localparam logic [3:0] ADDR_COMMIT  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  // A zero-length region would break the counter wrap logic, so it is stored as one.
  function automatic tfield_t clamp_field(input tfield_t wdata);
    return (wdata == 12'd0) ? 12'd1 : wdata;
  endfunction

  function automatic logic [23:0] bar_rgb(input logic [3:0] idx);
    case (idx)
      4'd0:    return RGB_WHITE;
      4'd1:    return RGB_YELLOW;
      4'd2:    return RGB_CYAN;
      4'd3:    return RGB_GREEN;
      4'd4:    return RGB_MAGENTA;
      4'd5:    return RGB_RED;
      4'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/tpg_colour_bar.sv
// Eight vertical colour bars; bar width is max(h_active>>3,1), tracked with a
// position counter. Output is registered so it lines up with the registered de.
module tpg_colour_bar
  import vid_timing_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_in,
  input  tfield_t     h_active,
  output logic [23:0] vdata
);

  tfield_t     bar_w;
  tfield_t     pos_q, pos_d;
  logic [3:0]  idx_q, idx_d;
  logic [23:0] vdata_q, vdata_d;

  always_comb begin
    bar_w   = (h_active[11:3] == 9'd0) ? 12'd1 : {3'd0, h_active[11:3]};
    pos_d   = '0;
    idx_d   = '0;
    vdata_d = '0;
    if (de_in) begin
      vdata_d = bar_rgb(idx_q);
      if (pos_q == bar_w - 12'd1) begin
        pos_d = '0;
        // Saturate at index 8 so any leftover pixels stay black.
        idx_d = (idx_q == 4'd8) ? idx_q : idx_q + 4'd1;
      end else begin
        pos_d = pos_q + 12'd1;
        idx_d = idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      idx_q   <= '0;
      vdata_q <= '0;
    end else begin
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      vdata_q <= vdata_d;
    end
  end

  assign vdata = vdata_q;

endmodule

// File: rtl/vid_timing_ctrl.sv
// Programmable raster timing generator with double-buffered timing registers.
// Define VID_TIMING_TPG_EN to build the colour-bar pattern on vdata.
module vid_timing_ctrl
  import vid_timing_pkg::*;
#(
  parameter tfield_t H_ACTIVE = 12'd640,
  parameter tfield_t H_FP     = 12'd16,
  parameter tfield_t H_SYNC   = 12'd96,
  parameter tfield_t H_BP     = 12'd48,
  parameter tfield_t V_ACTIVE = 12'd480,
  parameter tfield_t V_FP     = 12'd10,
  parameter tfield_t V_SYNC   = 12'd2,
  parameter tfield_t V_BP     = 12'd33,
  parameter logic    HS_POL   = 1'b0,
  parameter logic    VS_POL   = 1'b0
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        en,
  input  logic        cfg_wr,
  input  logic [3:0]  cfg_addr,
  input  logic [11:0] cfg_wdata,
  output logic        cfg_ack,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        sof,
  output logic        busy,
  output logic [23:0] vdata
);

  localparam tfield_t FLD_DEFAULT [NUM_FLD] =
    '{H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP};

  state_t  state_q, state_d;
  tfield_t h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  tfield_t act_q [NUM_FLD];
  tfield_t act_d [NUM_FLD];
  tfield_t shd_q [NUM_FLD];
  tfield_t shd_d [NUM_FLD];
  logic    pending_q, pending_d;

  logic    cfg_ack_q, cfg_ack_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic    de_q, de_d, sof_q, sof_d, busy_q, busy_d;
  tfield_t x_q, x_d, y_q, y_d;

  tfield_t h_sync_start, h_sync_end, h_total;
  tfield_t v_sync_start, v_sync_end, v_total;
  logic    run, last_h, last_v, last_pix, commit_now, xfer;

  // Region boundaries, all modulo 4096.
  always_comb begin
    h_sync_start = act_q[FLD_H_ACTIVE] + act_q[FLD_H_FP];
    h_sync_end   = h_sync_start + act_q[FLD_H_SYNC];
    h_total      = h_sync_end + act_q[FLD_H_BP];
    v_sync_start = act_q[FLD_V_ACTIVE] + act_q[FLD_V_FP];
    v_sync_end   = v_sync_start + act_q[FLD_V_SYNC];
    v_total      = v_sync_end + act_q[FLD_V_BP];
    run          = (state_q == RUN);
    last_h       = (h_cnt_q == h_total - 12'd1);
    last_v       = (v_cnt_q == v_total - 12'd1);
    last_pix     = run && last_h && last_v;
    commit_now   = cfg_wr && (cfg_addr == ADDR_COMMIT);
    // A commit landing on the last pixel is honoured at that same frame end.
    xfer         = run ? (last_pix && (pending_q || commit_now)) : pending_q;
  end

  always_comb begin
    state_d = state_q;
    h_cnt_d = '0;
    v_cnt_d = '0;
    case (state_q)
      IDLE: if (en) state_d = RUN;
      RUN: begin
        if (last_pix && !en) state_d = IDLE;
        if (!last_h) begin
          h_cnt_d = h_cnt_q + 12'd1;
          v_cnt_d = v_cnt_q;
        end else if (!last_v) begin
          v_cnt_d = v_cnt_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    cfg_ack_d = xfer;
    for (int i = 0; i < NUM_FLD; i++) begin
      shd_d[i] = shd_q[i];
      act_d[i] = xfer ? shd_q[i] : act_q[i];
    end
    if (cfg_wr && !cfg_addr[3]) shd_d[cfg_addr[2:0]] = clamp_field(cfg_wdata);
    if (xfer) pending_d = 1'b0;
    // In IDLE a fresh commit arriving during a transfer needs its own transfer.
    if (commit_now && !(xfer && run)) pending_d = 1'b1;
  end

  always_comb begin
    de_d    = run && (h_cnt_q < act_q[FLD_H_ACTIVE]) && (v_cnt_q < act_q[FLD_V_ACTIVE]);
    hsync_d = (run && (h_cnt_q >= h_sync_start) && (h_cnt_q < h_sync_end)) ? HS_POL : ~HS_POL;
    vsync_d = (run && (v_cnt_q >= v_sync_start) && (v_cnt_q < v_sync_end)) ? VS_POL : ~VS_POL;
    x_d     = de_d ? h_cnt_q : 12'd0;
    y_d     = de_d ? v_cnt_q : 12'd0;
    sof_d   = de_d && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    busy_d  = run;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pending_q <= 1'b0;
      for (int i = 0; i < NUM_FLD; i++) begin
        act_q[i] <= FLD_DEFAULT[i];
        shd_q[i] <= FLD_DEFAULT[i];
      end
      cfg_ack_q <= 1'b0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      de_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      sof_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      pending_q <= pending_d;
      for (int i = 0; i < NUM_FLD; i++) begin
        act_q[i] <= act_d[i];
        shd_q[i] <= shd_d[i];
      end
      cfg_ack_q <= cfg_ack_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      x_q       <= x_d;
      y_q       <= y_d;
      sof_q     <= sof_d;
      busy_q    <= busy_d;
    end
  end

  assign cfg_ack = cfg_ack_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign de      = de_q;
  assign x       = x_q;
  assign y       = y_q;
  assign sof     = sof_q;
  assign busy    = busy_q;

`ifdef VID_TIMING_TPG_EN
  tpg_colour_bar u_tpg (
    .clk      (CLK),
    .rst_n    (RSTn),
    .de_in    (de_d),
    .h_active (act_q[FLD_H_ACTIVE]),
    .vdata    (vdata)
  );
`else
  assign vdata = 24'h0;
`endif

endmodule
